// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the RV32 core pipeline:
//   - inter-stage payload structs and their widths (IF/ID ... MEM/WB)
//   - SKID_ON / SKID_OFF mode constants for pipe_stage
//   - occupancy encoding used by the two-entry skid stage
// -----------------------------------------------------------------------------
package core_pkg;

   // pipe_stage mode selection
   localparam bit SKID_ON  = 1'b1;
   localparam bit SKID_OFF = 1'b0;

   // IF/ID payload
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifid_t;

   // ID/EX payload
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [7:0]  ctrl;
   } idex_t;

   // EX/MEM payload
   typedef struct packed {
      logic [31:0] alu_out;
      logic [31:0] rs2_val;
      logic [4:0]  rd;
      logic [3:0]  ctrl;
   } exmem_t;

   // MEM/WB payload
   typedef struct packed {
      logic [31:0] alu_out;
      logic [31:0] rdatamem;
   } memwb_t;

   localparam int unsigned IFID_W  = $bits(ifid_t);
   localparam int unsigned IDEX_W  = $bits(idex_t);
   localparam int unsigned EXMEM_W = $bits(exmem_t);
   localparam int unsigned MEMWB_W = $bits(memwb_t);

   // Skid-stage occupancy. Encoded so that bit 0 is "out reg valid" and
   // bit 1 is "skid reg valid"; both handshake outputs then come straight
   // from a state flop.
   typedef enum logic [1:0] {
      OccEmpty = 2'b00,
      OccOne   = 2'b01,
      OccTwo   = 2'b11
   } occ_e;

endpackage : core_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter for performance statistics. Clear wins over increment.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   inc    in   count one this cycle (ignored once saturated)
//   clr    in   synchronous clear to zero
//   cnt    out  current count [W-1:0]
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] r_cnt;
   logic [W-1:0] w_cnt_next;

   always_comb begin
      w_cnt_next = r_cnt;
      if (clr) begin
         w_cnt_next = '0;
      end else if (inc && (r_cnt != {W{1'b1}})) begin
         w_cnt_next = r_cnt + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_next;
      end
   end

   assign cnt = r_cnt;

endmodule : sat_counter

// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
// Pipeline stage register with valid/ready flow control, synchronous flush and
// an optional two-entry skid buffer. Beats are passed strictly in order.
// Parameters:
//   DATA_W  payload width
//   SKID    SKID_ON: two-entry stage, in_ready registered
//           SKID_OFF: single-entry stage, in_ready combinational from out_ready
//   CNT_W   stall counter width
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream beat present
//   in_ready   out  stage accepts a beat this cycle
//   in_data    in   upstream payload [DATA_W-1:0]
//   out_valid  out  downstream beat present
//   out_ready  in   downstream consumes the beat this cycle
//   out_data   out  downstream payload [DATA_W-1:0]
//   flush      in   drop all held beats (and any beat accepted this cycle)
//   stall_clr  in   clear stall_cnt
//   stall_cnt  out  saturating count of out_valid & ~out_ready cycles
// -----------------------------------------------------------------------------
module pipe_stage
   import core_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter bit          SKID   = SKID_ON,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   input  logic              stall_clr,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic w_accept;
   logic w_emit;
   logic w_stall;

   assign w_accept = in_valid & in_ready;
   assign w_emit   = out_valid & out_ready;
   assign w_stall  = out_valid & ~out_ready;

   generate
      if (SKID) begin : g_skid
         occ_e              r_occ;
         occ_e              w_occ_next;
         logic [DATA_W-1:0] r_out_data;
         logic [DATA_W-1:0] r_skid_data;
         logic [DATA_W-1:0] w_out_data_next;
         logic [DATA_W-1:0] w_skid_data_next;

         always_comb begin
            w_occ_next       = r_occ;
            w_out_data_next  = r_out_data;
            w_skid_data_next = r_skid_data;
            unique case (r_occ)
               OccEmpty: begin
                  if (w_accept) begin
                     w_occ_next      = OccOne;
                     w_out_data_next = in_data;
                  end
               end
               OccOne: begin
                  if (w_accept && w_emit) begin
                     w_out_data_next = in_data;
                  end else if (w_accept) begin
                     // Downstream blocked: park the new beat behind the out reg.
                     w_occ_next       = OccTwo;
                     w_skid_data_next = in_data;
                  end else if (w_emit) begin
                     w_occ_next = OccEmpty;
                  end
               end
               OccTwo: begin
                  // in_ready is low here, so only an emit can move state.
                  if (w_emit) begin
                     w_occ_next      = OccOne;
                     w_out_data_next = r_skid_data;
                  end
               end
               default: begin
                  w_occ_next = OccEmpty;
               end
            endcase
            // Flush clears valids only; payload registers keep their contents.
            if (flush) begin
               w_occ_next       = OccEmpty;
               w_out_data_next  = r_out_data;
               w_skid_data_next = r_skid_data;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_occ       <= OccEmpty;
               r_out_data  <= '0;
               r_skid_data <= '0;
            end else begin
               r_occ       <= w_occ_next;
               r_out_data  <= w_out_data_next;
               r_skid_data <= w_skid_data_next;
            end
         end

         assign out_valid = r_occ[0];
         assign in_ready  = ~r_occ[1];
         assign out_data  = r_out_data;

      end else begin : g_single
         logic              r_valid;
         logic [DATA_W-1:0] r_data;
         logic              w_valid_next;
         logic [DATA_W-1:0] w_data_next;

         always_comb begin
            w_valid_next = r_valid;
            w_data_next  = r_data;
            if (flush) begin
               w_valid_next = 1'b0;
            end else if (w_accept) begin
               w_valid_next = 1'b1;
               w_data_next  = in_data;
            end else if (w_emit) begin
               w_valid_next = 1'b0;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_valid <= 1'b0;
               r_data  <= '0;
            end else begin
               r_valid <= w_valid_next;
               r_data  <= w_data_next;
            end
         end

         // Bubble-free: a full register can still take a beat when it empties
         // in the same cycle. This is a combinational out_ready -> in_ready path.
         assign in_ready  = ~r_valid | out_ready;
         assign out_valid = r_valid;
         assign out_data  = r_data;
      end
   endgenerate

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_stall),
      .clr   (stall_clr),
      .cnt   (stall_cnt)
   );

endmodule : pipe_stage

// File: tb/tb_pipe_stage.sv
module tb_pipe_stage;
   import core_pkg::*;

   localparam int unsigned AW   = MEMWB_W;
   localparam int unsigned AC   = 4;
   localparam int unsigned BW   = 32;
   localparam int unsigned BC   = 16;
   localparam int unsigned AMAX = (1 << AC) - 1;
   localparam int unsigned BMAX = (1 << BC) - 1;

   logic clk;
   logic rst_n;

   // DUT A: skid mode, 64-bit payload, 4-bit stall counter
   logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush, a_stall_clr;
   logic [AW-1:0] a_in_data, a_out_data;
   logic [AC-1:0] a_stall_cnt;
   // DUT B: single-entry mode, 32-bit payload, 16-bit stall counter
   logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush, b_stall_clr;
   logic [BW-1:0] b_in_data, b_out_data;
   logic [BC-1:0] b_stall_cnt;

   int n_checks;
   int n_fails;

   // Reference models: a bounded FIFO per DUT plus a stall count.
   logic [AW-1:0] a_q[$];
   logic [AW-1:0] a_log[$];
   int            a_cnt;
   bit            a_hold;
   logic [BW-1:0] b_q[$];
   logic [BW-1:0] b_log[$];
   int            b_cnt;
   bit            b_hold;

   pipe_stage #(.DATA_W(AW), .SKID(SKID_ON), .CNT_W(AC)) u_dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_data   (a_in_data),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_data  (a_out_data),
      .flush     (a_flush),
      .stall_clr (a_stall_clr),
      .stall_cnt (a_stall_cnt)
   );

   pipe_stage #(.DATA_W(BW), .SKID(SKID_OFF), .CNT_W(BC)) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .flush     (b_flush),
      .stall_clr (b_stall_clr),
      .stall_cnt (b_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Skid stage behaves as a 2-deep FIFO whose in_ready depends only on its fill.
   task automatic model_a();
      bit ir, ov, acc, emi;
      ir = (a_q.size() < 2);
      ov = (a_q.size() != 0);
      check("a.in_ready", 64'(a_in_ready), 64'(ir));
      check("a.out_valid", 64'(a_out_valid), 64'(ov));
      if (ov) check("a.out_data", a_out_data, a_q[0]);
      check("a.stall_cnt", 64'(a_stall_cnt), 64'(a_cnt));
      acc = a_in_valid && ir;
      emi = ov && a_out_ready;
      if (a_stall_clr) a_cnt = 0;
      else if (ov && !a_out_ready && a_cnt < AMAX) a_cnt++;
      if (emi) a_log.push_back(a_q[0]);
      if (a_flush) a_q.delete();
      else begin
         if (emi) void'(a_q.pop_front());
         if (acc) a_q.push_back(a_in_data);
      end
      a_hold = a_in_valid && !acc;
   endtask

   // Single-entry stage: 1-deep FIFO that may refill in the cycle it drains.
   task automatic model_b();
      bit ir, ov, acc, emi;
      ov = (b_q.size() != 0);
      ir = !ov || b_out_ready;
      check("b.in_ready", 64'(b_in_ready), 64'(ir));
      check("b.out_valid", 64'(b_out_valid), 64'(ov));
      if (ov) check("b.out_data", 64'(b_out_data), 64'(b_q[0]));
      check("b.stall_cnt", 64'(b_stall_cnt), 64'(b_cnt));
      acc = b_in_valid && ir;
      emi = ov && b_out_ready;
      if (b_stall_clr) b_cnt = 0;
      else if (ov && !b_out_ready && b_cnt < BMAX) b_cnt++;
      if (emi) b_log.push_back(b_q[0]);
      if (b_flush) b_q.delete();
      else begin
         if (emi) void'(b_q.pop_front());
         if (acc) b_q.push_back(b_in_data);
      end
      b_hold = b_in_valid && !acc;
   endtask

   task automatic tick();
      @(negedge clk);
      model_a();
      model_b();
      @(posedge clk);
      #1;
   endtask

   task automatic models_reset();
      a_q.delete(); b_q.delete();
      a_cnt = 0; b_cnt = 0; a_hold = 0; b_hold = 0;
      a_in_valid = 0; a_in_data = '0; a_out_ready = 0; a_flush = 0; a_stall_clr = 0;
      b_in_valid = 0; b_in_data = '0; b_out_ready = 0; b_flush = 0; b_stall_clr = 0;
   endtask

   initial begin
      int dead;
      int bias;
      n_checks = 0;
      n_fails  = 0;
      rst_n    = 1'b0;
      models_reset();
      #3;
      check("rst.a_out_valid", 64'(a_out_valid), 64'(0));
      check("rst.a_out_data", a_out_data, 64'(0));
      check("rst.a_in_ready", 64'(a_in_ready), 64'(1));
      check("rst.a_stall_cnt", 64'(a_stall_cnt), 64'(0));
      check("rst.b_out_valid", 64'(b_out_valid), 64'(0));
      check("rst.b_in_ready", 64'(b_in_ready), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Streaming 0x1..0x8 with downstream always ready.
      a_out_ready = 1;
      for (int i = 1; i <= 8; i++) begin
         a_in_valid = 1;
         a_in_data  = AW'(i);
         tick();
         check("stream.latency_valid", 64'(a_out_valid), 64'(1));
         check("stream.latency_data", a_out_data, 64'(i));
      end
      a_in_valid = 0;
      tick();
      tick();
      check("stream.count", 64'(a_log.size()), 64'(8));
      for (int i = 0; i < a_log.size(); i++) check("stream.order", a_log[i], 64'(i + 1));
      check("stream.stall_cnt", 64'(a_stall_cnt), 64'(0));

      // Back-pressure: 0xA, 0xB absorbed, 0xC waits; three stall cycles.
      a_log.delete();
      a_out_ready = 0;
      a_in_valid  = 1;
      a_in_data   = AW'('hA);
      tick();
      a_in_data = AW'('hB);
      tick();
      check("bp.in_ready_low", 64'(a_in_ready), 64'(0));
      a_in_data = AW'('hC);
      tick();
      tick();
      check("bp.stall_cnt", 64'(a_stall_cnt), 64'(3));
      a_out_ready = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!a_hold) a_in_valid = 0;
      end
      check("bp.count", 64'(a_log.size()), 64'(3));
      if (a_log.size() == 3) begin
         check("bp.order0", a_log[0], 64'('hA));
         check("bp.order1", a_log[1], 64'('hB));
         check("bp.order2", a_log[2], 64'('hC));
      end

      // Single-entry mode: full stage stalls upstream in the same cycle.
      b_log.delete();
      b_out_ready = 0;
      b_in_valid  = 1;
      b_in_data   = 32'h5;
      tick();
      b_in_data = 32'h6;
      #1;
      check("b.bubble_ready_low", 64'(b_in_ready), 64'(0));
      tick();
      b_out_ready = 1;
      #1;
      check("b.bubble_ready_high", 64'(b_in_ready), 64'(1));
      tick();
      b_in_valid = 0;
      check("b.accept_emit_log", 64'(b_log.size()), 64'(1));
      if (b_log.size() == 1) check("b.accept_emit_first", 64'(b_log[0]), 64'(5));
      check("b.accept_emit_data", 64'(b_out_data), 64'(6));
      tick();
      tick();

      // Flush at occupancy 2, then flush with a concurrent accept of 0xDEAD.
      a_out_ready = 0;
      a_in_valid  = 1;
      a_in_data   = AW'('h11);
      tick();
      a_in_data = AW'('h22);
      tick();
      a_in_valid = 0;
      a_flush    = 1;
      tick();
      a_flush = 0;
      check("flush.out_valid", 64'(a_out_valid), 64'(0));
      check("flush.in_ready", 64'(a_in_ready), 64'(1));
      a_in_valid = 1;
      a_in_data  = AW'('h33);
      tick();
      a_log.delete();
      b_log.delete();
      a_in_data  = AW'('hDEAD);
      a_flush    = 1;
      b_in_valid = 1;
      b_in_data  = 32'hDEAD;
      b_flush    = 1;
      tick();
      a_in_valid = 0; a_flush = 0; b_in_valid = 0; b_flush = 0;
      check("flush.a_out_valid", 64'(a_out_valid), 64'(0));
      check("flush.b_out_valid", 64'(b_out_valid), 64'(0));
      a_out_ready = 1;
      b_out_ready = 1;
      for (int i = 0; i < 4; i++) tick();
      dead = 0;
      foreach (a_log[i]) if (a_log[i] == AW'('hDEAD)) dead++;
      foreach (b_log[i]) if (b_log[i] == 32'hDEAD) dead++;
      check("flush.dead_seen", 64'(dead), 64'(0));

      // Counter saturation at 15 and clear-wins-over-increment.
      a_out_ready = 0;
      a_in_valid  = 1;
      a_in_data   = AW'('h44);
      a_stall_clr = 1;
      tick();
      a_in_valid  = 0;
      a_stall_clr = 0;
      for (int i = 0; i < 20; i++) tick();
      check("sat.stall_cnt", 64'(a_stall_cnt), 64'(15));
      a_stall_clr = 1;
      tick();
      a_stall_clr = 0;
      check("sat.clear", 64'(a_stall_cnt), 64'(0));
      a_flush = 1;
      tick();
      a_flush = 0;

      // Async reset mid-cycle at occupancy 2.
      a_in_valid = 1;
      a_in_data  = AW'('h77);
      tick();
      a_in_data = AW'('h88);
      tick();
      a_in_valid = 0;
      #2;
      rst_n = 1'b0;
      #1;
      check("areset.out_valid", 64'(a_out_valid), 64'(0));
      check("areset.out_data", a_out_data, 64'(0));
      check("areset.in_ready", 64'(a_in_ready), 64'(1));
      check("areset.stall_cnt", 64'(a_stall_cnt), 64'(0));
      models_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Randomised traffic on both DUTs against the FIFO models.
      for (int i = 0; i < 3000; i++) begin
         bias = ((i / 256) % 2 == 1) ? 2 : 6;
         if (!a_hold) begin
            a_in_valid = ($urandom_range(0, 3) != 0);
            a_in_data  = {$urandom(), $urandom()};
         end
         a_out_ready = ($urandom_range(0, 7) < bias);
         a_flush     = ($urandom_range(0, 31) == 0);
         a_stall_clr = ($urandom_range(0, 63) == 0);
         if (!b_hold) begin
            b_in_valid = ($urandom_range(0, 3) != 0);
            b_in_data  = $urandom();
         end
         b_out_ready = ($urandom_range(0, 7) < bias);
         b_flush     = ($urandom_range(0, 31) == 0);
         b_stall_clr = ($urandom_range(0, 63) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_pipe_stage
